// File: rtl/stg1ia_fq.sv
// Stage-1 instruction-address generator: owns the fetch PC, issues one fetch per cycle
// and queues issued PCs toward stage 2. Optional perf counters under STG1IA_FQ_PERF_EN.
module stg1ia_fq #(
  parameter int                ADDR_W   = 24,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1,
  parameter int                DEPTH    = 4
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic              iw_hold,
  input  logic              iw_redirect,
  input  logic [ADDR_W-1:0] iw_redirect_pc,
  output logic              ow_mem_req,
  output logic [ADDR_W-1:0] ow_mem_addr,
  output logic [ADDR_W-1:0] ow_pc,
  output logic              ow_ia_valid,
  input  logic              iw_id_ready
`ifdef STG1IA_FQ_PERF_EN
  ,
  output logic [31:0]       ow_perf_stall,
  output logic [31:0]       ow_perf_redir
`endif
);

  localparam int                PTR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
  localparam logic [PTR_W:0]    FULL  = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  logic w_pop;
  logic w_space;
  logic w_issue;

  // Redirect masks the head so stage 2 never consumes a PC that is being flushed.
  assign ow_ia_valid = (r_count != '0) & ~iw_redirect;
  assign w_pop       = ow_ia_valid & iw_id_ready;
  assign w_space     = (r_count < FULL) | w_pop;
  // Reset gates issue so the fetch request is quiet while the block is held in reset.
  assign w_issue     = iw_rst_n & ~iw_hold & ~iw_redirect & w_space;

  assign ow_mem_req  = w_issue;
  assign ow_mem_addr = r_pc;
  assign ow_pc       = r_mem[r_head];

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!iw_rst_n) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (iw_redirect) begin
      r_pc    <= iw_redirect_pc;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_issue) begin
        r_pc   <= r_pc + STEP;
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_issue, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    // NOTE: the queue storage is reset so the head reads 0 out of reset instead of X.
    if (!iw_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_issue) begin
      r_mem[r_tail] <= r_pc;
    end
  end

`ifdef STG1IA_FQ_PERF_EN
  logic        w_stall;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redir;

  assign w_stall = ~iw_hold & ~iw_redirect & ~w_space;

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_perf_stall <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
      if (iw_redirect && r_perf_redir != '1) r_perf_redir <= r_perf_redir + 32'd1;
    end
  end

  assign ow_perf_stall = r_perf_stall;
  assign ow_perf_redir = r_perf_redir;
`endif

endmodule

// File: tb/tb_stg1ia_fq.sv
// Bench for stg1ia_fq: queue-based reference model compared every cycle, plus directed
// literal checks of the reset, issue, backpressure, redirect, wrap and hold behaviour.
module tb_stg1ia_fq;

  localparam int DEPTH = 4;

  logic        iw_clk = 1'b0;
  logic        iw_rst_n = 1'b0;
  logic        iw_hold = 1'b0;
  logic        iw_redirect = 1'b0;
  logic [23:0] iw_redirect_pc = '0;
  logic        iw_id_ready = 1'b1;

  logic        ow_mem_req,  ow_ia_valid,  ow8_mem_req, ow8_ia_valid;
  logic [23:0] ow_mem_addr, ow_pc;
  logic [7:0]  ow8_mem_addr, ow8_pc;
`ifdef STG1IA_FQ_PERF_EN
  logic [31:0] ow_perf_stall, ow_perf_redir, ow8_perf_stall, ow8_perf_redir;
`endif

  int checks = 0;
  int failures = 0;

  always #5 iw_clk = ~iw_clk;

  stg1ia_fq #(.ADDR_W(24), .RESET_PC(24'h0), .PC_STEP(1), .DEPTH(DEPTH)) u_dut (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_hold(iw_hold), .iw_redirect(iw_redirect),
    .iw_redirect_pc(iw_redirect_pc), .ow_mem_req(ow_mem_req), .ow_mem_addr(ow_mem_addr),
    .ow_pc(ow_pc), .ow_ia_valid(ow_ia_valid), .iw_id_ready(iw_id_ready)
`ifdef STG1IA_FQ_PERF_EN
    , .ow_perf_stall(ow_perf_stall), .ow_perf_redir(ow_perf_redir)
`endif
  );

  stg1ia_fq #(.ADDR_W(8), .RESET_PC(8'h0), .PC_STEP(1), .DEPTH(DEPTH)) u_dut8 (
    .iw_clk(iw_clk), .iw_rst_n(iw_rst_n), .iw_hold(iw_hold), .iw_redirect(iw_redirect),
    .iw_redirect_pc(iw_redirect_pc[7:0]), .ow_mem_req(ow8_mem_req), .ow_mem_addr(ow8_mem_addr),
    .ow_pc(ow8_pc), .ow_ia_valid(ow8_ia_valid), .iw_id_ready(iw_id_ready)
`ifdef STG1IA_FQ_PERF_EN
    , .ow_perf_stall(ow8_perf_stall), .ow_perf_redir(ow8_perf_redir)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the in-flight queue is a plain SV queue, the PC a 24-bit integer.
  logic [23:0] m_q[$];
  logic [23:0] m_pc = '0;
  int unsigned m_stall = 0;
  int unsigned m_redir = 0;

  function automatic void m_eval(output logic valid, output logic pop,
                                 output logic space, output logic issue);
    valid = (m_q.size() != 0) && !iw_redirect;
    pop   = valid && iw_id_ready;
    space = (m_q.size() < DEPTH) || pop;
    issue = iw_rst_n && !iw_hold && !iw_redirect && space;
  endfunction

  initial forever begin
    logic v, p, s, is;
    @(posedge iw_clk or negedge iw_rst_n);
    if (!iw_rst_n) begin
      m_q.delete();
      m_pc = '0;
      m_stall = 0;
      m_redir = 0;
    end else begin
      m_eval(v, p, s, is);
      if (!iw_hold && !iw_redirect && !s) m_stall++;
      if (iw_redirect) begin
        m_redir++;
        m_q.delete();
        m_pc = iw_redirect_pc;
      end else begin
        if (p) void'(m_q.pop_front());
        if (is) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 24'd1;
        end
      end
    end
  end

  always @(negedge iw_clk) begin
    logic v, p, s, is;
    m_eval(v, p, s, is);
    check("cmp_mem_req",   32'(ow_mem_req),   32'(is));
    check("cmp_mem_addr",  32'(ow_mem_addr),  32'(m_pc));
    check("cmp_ia_valid",  32'(ow_ia_valid),  32'(v));
    check("cmp8_mem_req",  32'(ow8_mem_req),  32'(is));
    check("cmp8_mem_addr", 32'(ow8_mem_addr), 32'(m_pc[7:0]));
    check("cmp8_ia_valid", 32'(ow8_ia_valid), 32'(v));
    if (v) begin
      check("cmp_pc",  32'(ow_pc),  32'(m_q[0]));
      check("cmp8_pc", 32'(ow8_pc), 32'(m_q[0][7:0]));
    end else if (!iw_rst_n) begin
      check("cmp_pc_rst",  32'(ow_pc),  32'h0);
      check("cmp8_pc_rst", 32'(ow8_pc), 32'h0);
    end
`ifdef STG1IA_FQ_PERF_EN
    check("cmp_perf_stall", ow_perf_stall, m_stall);
    check("cmp_perf_redir", ow_perf_redir, m_redir);
    check("cmp8_perf_stall", ow8_perf_stall, m_stall);
`endif
  end

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  initial begin
    // Reset state, then release off the clock edge.
    #12;
    check("rst_mem_req", 32'(ow_mem_req), 32'h0);
    check("rst_valid", 32'(ow_ia_valid), 32'h0);
    check("rst_pc", 32'(ow_pc), 32'h0);
    check("rst_mem_addr", 32'(ow_mem_addr), 32'h0);
    iw_rst_n = 1'b1;
    #1;
    check("s1_req0", 32'(ow_mem_req), 32'h1);
    check("s1_addr0", 32'(ow_mem_addr), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      #1;
      check("s1_addr", 32'(ow_mem_addr), 32'(k));
      check("s1_valid", 32'(ow_ia_valid), 32'h1);
      check("s1_pc", 32'(ow_pc), 32'(k - 1));
    end

    // Backpressure from reset: fill, stall, then pop and issue together.
    iw_id_ready = 1'b0;
    iw_rst_n = 1'b0;
    #1;
    iw_rst_n = 1'b1;
    repeat (4) tick();
    #1;
    check("s2_full_req", 32'(ow_mem_req), 32'h0);
    check("s2_full_valid", 32'(ow_ia_valid), 32'h1);
    check("s2_full_pc", 32'(ow_pc), 32'h0);
    check("s2_full_addr", 32'(ow_mem_addr), 32'h4);
    tick();
    iw_id_ready = 1'b1;
    #1;
    check("s2_pp_req", 32'(ow_mem_req), 32'h1);
    check("s2_pp_addr", 32'(ow_mem_addr), 32'h4);
    check("s2_pp_pc", 32'(ow_pc), 32'h0);
    tick();
    #1;
    check("s2_next_pc", 32'(ow_pc), 32'h1);
    check("s2_next_addr", 32'(ow_mem_addr), 32'h5);

    // Redirect with a full queue and ready high.
    iw_redirect = 1'b1;
    iw_redirect_pc = 24'h000100;
    #1;
    check("s3_valid", 32'(ow_ia_valid), 32'h0);
    check("s3_req", 32'(ow_mem_req), 32'h0);
    tick();
    iw_redirect = 1'b0;
    #1;
    check("s3_addr", 32'(ow_mem_addr), 32'h100);
    check("s3_empty", 32'(ow_ia_valid), 32'h0);
    check("s3_req1", 32'(ow_mem_req), 32'h1);
    tick();
    #1;
    check("s3_pc", 32'(ow_pc), 32'h100);
    check("s3_valid1", 32'(ow_ia_valid), 32'h1);
    check("s3_addr1", 32'(ow_mem_addr), 32'h101);

    // Wrap at the top of the address space for both widths.
    iw_redirect = 1'b1;
    iw_redirect_pc = 24'hFFFFFF;
    tick();
    iw_redirect = 1'b0;
    #1;
    check("s4_addr", 32'(ow_mem_addr), 32'hFFFFFF);
    check("s4_addr8", 32'(ow8_mem_addr), 32'hFF);
    tick();
    #1;
    check("s4_wrap", 32'(ow_mem_addr), 32'h0);
    check("s4_wrap8", 32'(ow8_mem_addr), 32'h0);
    check("s4_pc", 32'(ow_pc), 32'hFFFFFF);
    check("s4_pc8", 32'(ow8_pc), 32'hFF);

    // Hold with two entries queued: queue drains, PC stays frozen.
    iw_redirect = 1'b1;
    iw_redirect_pc = 24'h000040;
    iw_id_ready = 1'b0;
    tick();
    iw_redirect = 1'b0;
    repeat (2) tick();
    iw_hold = 1'b1;
    iw_id_ready = 1'b1;
    #1;
    check("s5_req", 32'(ow_mem_req), 32'h0);
    check("s5_pc0", 32'(ow_pc), 32'h40);
    tick();
    #1;
    check("s5_pc1", 32'(ow_pc), 32'h41);
    check("s5_frozen", 32'(ow_mem_addr), 32'h42);
    tick();
    #1;
    check("s5_drained", 32'(ow_ia_valid), 32'h0);
    check("s5_frozen2", 32'(ow_mem_addr), 32'h42);
    tick();
    iw_hold = 1'b0;
    #1;
    check("s5_resume_req", 32'(ow_mem_req), 32'h1);
    check("s5_resume_addr", 32'(ow_mem_addr), 32'h42);

    // Asynchronous reset in the middle of traffic.
    repeat (3) tick();
    #2;
    iw_rst_n = 1'b0;
    #1;
    check("s6_req", 32'(ow_mem_req), 32'h0);
    check("s6_valid", 32'(ow_ia_valid), 32'h0);
    check("s6_pc", 32'(ow_pc), 32'h0);
    check("s6_addr", 32'(ow_mem_addr), 32'h0);
`ifdef STG1IA_FQ_PERF_EN
    check("s6_perf_stall", ow_perf_stall, 32'h0);
    check("s6_perf_redir", ow_perf_redir, 32'h0);
`endif
    tick();
    iw_rst_n = 1'b1;
    repeat (3) tick();
    #1;
    check("s6_after_addr", 32'(ow_mem_addr), 32'h3);
    check("s6_after_pc", 32'(ow_pc), 32'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
